alu_pipe: RTL and testbench

Parametrised, 2-stage pipelined successor of the CPU's single-cycle 16-bit ALU. It supports the same eight operations, generalised to WIDTH bits. It adds saturating add/sub, valid/ready handshakes with back-pressure, and an internal architectural flag register (Z, V, N) with per-opcode update rules. It sits between the decode/operand-fetch stage and the writeback stage.

---
 rtl/alu_pipe.sv | 203 ++++++++++++++++++++
 tb/tb_alu_pipe.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with saturating arithmetic, valid/ready
// handshakes on both sides and an architectural Z/V/N flag register.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid, in_ready  input handshake; an op transfers when both are high
//   opcode              0 ADD, 1 SUB, 2 XOR, 3 RED, 4 SLL, 5 SRA, 6 ROR, 7 PADDSB
//   in1, in2            operands (in2[SHW-1:0] is the shift/rotate amount)
//   out_valid, out_ready output handshake; a result transfers when both are high
//   result              result of the op held in stage 2
//   flags               flag register {Z, V, N}
//
// Handshake semantics: a producer holding valid high keeps its payload stable
// until the matching ready is seen high at a rising edge; ready never depends
// on the same-side valid. in_ready does depend on out_ready (combinational).
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags
);

    localparam logic [2:0] OP_ADD    = 3'd0;
    localparam logic [2:0] OP_SUB    = 3'd1;
    localparam logic [2:0] OP_XOR    = 3'd2;
    localparam logic [2:0] OP_RED    = 3'd3;
    localparam logic [2:0] OP_SLL    = 3'd4;
    localparam logic [2:0] OP_SRA    = 3'd5;
    localparam logic [2:0] OP_ROR    = 3'd6;
    localparam logic [2:0] OP_PADDSB = 3'd7;

    localparam int NB = WIDTH / 8;
    localparam int NL = WIDTH / 4;

    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Stage 1: captured operation
    logic             s1_valid;
    logic [2:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    // Stage 2: computed result; flag_q is the architectural flag register
    logic             s2_valid;
    logic [WIDTH-1:0] s2_result;
    logic [2:0]       flag_q;

    logic s2_load;
    logic s1_adv;
    logic s1_load;

    assign s2_load  = !s2_valid || out_ready;
    assign s1_adv   = s1_valid && s2_load;
    assign s1_load  = !s1_valid || s1_adv;
    assign in_ready = !s1_valid || !s2_valid || out_ready;

    assign out_valid = s2_valid;
    assign result    = s2_result;
    assign flags     = flag_q;

    // Datapath on the stage-1 operands
    logic [SHW-1:0]   sh;
    logic [SHW-1:0]   rot_amt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] sra_res;
    logic             add_ovf;
    logic             sub_ovf;

    assign sh      = s1_b[SHW-1:0];
    assign sum     = s1_a + s1_b;
    assign diff    = s1_a - s1_b;
    assign sra_res = $signed(s1_a) >>> sh;
    // Overflow: operands agree in sign (ADD) or differ (SUB) and the wrapped
    // result's sign disagrees with in1.
    assign add_ovf = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
    assign sub_ovf = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff[WIDTH-1] != s1_a[WIDTH-1]);
    // For non-power-of-two widths the amount field can exceed WIDTH-1; the
    // field is below 2*WIDTH so one subtraction reduces it modulo WIDTH.
    assign rot_amt = (int'(sh) >= WIDTH) ? SHW'(int'(sh) - WIDTH) : sh;

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] red_acc;
    logic [4:0]       lane_sum;
    logic             upd_z;
    logic             upd_vn;
    logic             v_new;
    logic             z_new;
    logic             n_new;

    always_comb begin
        alu_res  = '0;
        red_acc  = '0;
        lane_sum = '0;
        upd_z    = 1'b0;
        upd_vn   = 1'b0;
        v_new    = 1'b0;
        case (s1_op)
            OP_ADD: begin
                alu_res = add_ovf ? (s1_a[WIDTH-1] ? SAT_NEG : SAT_POS) : sum;
                v_new   = add_ovf;
                upd_z   = 1'b1;
                upd_vn  = 1'b1;
            end
            OP_SUB: begin
                alu_res = sub_ovf ? (s1_a[WIDTH-1] ? SAT_NEG : SAT_POS) : diff;
                v_new   = sub_ovf;
                upd_z   = 1'b1;
                upd_vn  = 1'b1;
            end
            OP_XOR: begin
                alu_res = s1_a ^ s1_b;
                upd_z   = 1'b1;
            end
            OP_RED: begin
                // The byte sum fits WIDTH bits for WIDTH >= 16; at WIDTH = 8
                // only the low bits are kept, which modulo arithmetic gives
                // exactly, so WIDTH-bit accumulation loses nothing visible.
                for (int i = 0; i < NB; i++) begin
                    red_acc = red_acc + WIDTH'($signed(s1_a[8*i +: 8]))
                                      + WIDTH'($signed(s1_b[8*i +: 8]));
                end
                alu_res = red_acc;
            end
            OP_SLL: begin
                alu_res = s1_a << sh;
                upd_z   = 1'b1;
            end
            OP_SRA: begin
                alu_res = sra_res;
                upd_z   = 1'b1;
            end
            OP_ROR: begin
                // Left term vanishes when rot_amt is 0 (shift by WIDTH).
                alu_res = (s1_a >> rot_amt) | (s1_a << (WIDTH - int'(rot_amt)));
                upd_z   = 1'b1;
            end
            OP_PADDSB: begin
                for (int l = 0; l < NL; l++) begin
                    lane_sum = 5'($signed(s1_a[4*l +: 4])) + 5'($signed(s1_b[4*l +: 4]));
                    if (lane_sum[4] != lane_sum[3]) begin
                        alu_res[4*l +: 4] = lane_sum[4] ? 4'b1000 : 4'b0111;
                    end else begin
                        alu_res[4*l +: 4] = lane_sum[3:0];
                    end
                end
            end
            default: ;
        endcase
    end

    assign z_new = (alu_res == '0);
    assign n_new = alu_res[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op <= opcode;
                s1_a  <= in1;
                s1_b  <= in2;
            end
        end
    end

    // Flags change only on the edge an op enters stage 2, so a stalled
    // stage 2 never re-applies its update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            flag_q    <= 3'b000;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result <= alu_res;
                if (upd_z) begin
                    flag_q[2] <= z_new;
                end
                if (upd_vn) begin
                    flag_q[1:0] <= {v_new, n_new};
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: WIDTH=16 instance driven through a scoreboard with a
// separate output monitor, plus a WIDTH=32 instance exercised directly.
module tb_alu_pipe;

    localparam int W  = 16;
    localparam int EW = W + 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT (WIDTH=16) ----------------
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    opcode;
    logic [W-1:0]  in1;
    logic [W-1:0]  in2;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [2:0]    flags;

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
        .in1(in1), .in2(in2),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    // ---------------- DUT (WIDTH=32) ----------------
    logic          in_valid32;
    logic          in_ready32;
    logic [2:0]    opcode32;
    logic [31:0]   a32;
    logic [31:0]   b32;
    logic          out_valid32;
    logic          out_ready32;
    logic [31:0]   result32;
    logic [2:0]    flags32;

    alu_pipe #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid32), .in_ready(in_ready32), .opcode(opcode32),
        .in1(a32), .in2(b32),
        .out_valid(out_valid32), .out_ready(out_ready32),
        .result(result32), .flags(flags32)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];
    logic [2:0]    mflags   = 3'b000;
    logic [2:0]    mflags32 = 3'b000;
    int            rdy_mode = 0;
    int            rdy_cnt  = 0;
    logic          stalled_prev = 1'b0;
    logic [W-1:0]  held_res = '0;
    logic [2:0]    held_flags = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint sx(input logic [63:0] v, input int w);
        return v[w-1] ? longint'(v) - (longint'(1) << w) : longint'(v);
    endfunction

    function automatic void model(input int w, input logic [2:0] op,
                                  input logic [63:0] a_in, input logic [63:0] b_in,
                                  input logic [2:0] fin,
                                  output logic [63:0] res, output logic [2:0] fout);
        longint mask, a, b, sa, sb, mx, mn, s, acc;
        int shw, sh, r;
        logic v;
        mask = (longint'(1) << w) - 1;
        a    = a_in & mask;
        b    = b_in & mask;
        sa   = sx(a, w);
        sb   = sx(b, w);
        mx   = (longint'(1) << (w - 1)) - 1;
        mn   = -mx - 1;
        shw  = 0;
        while ((1 << shw) < w) shw++;
        sh   = int'(b & ((longint'(1) << shw) - 1));
        v    = 1'b0;
        res  = '0;
        fout = fin;
        case (op)
            3'd0, 3'd1: begin
                s = (op == 3'd0) ? sa + sb : sa - sb;
                v = (s > mx) || (s < mn);
                if (s > mx) s = mx;
                if (s < mn) s = mn;
                res  = s & mask;
                fout = {res == 0, v, res[w-1]};
            end
            3'd2: begin
                res = a ^ b;
                fout[2] = (res == 0);
            end
            3'd3: begin
                acc = 0;
                for (int i = 0; i < w / 8; i++) begin
                    acc += sx((a >> (8 * i)) & 255, 8) + sx((b >> (8 * i)) & 255, 8);
                end
                res = acc & mask;
            end
            3'd4: begin
                res = (a << sh) & mask;
                fout[2] = (res == 0);
            end
            3'd5: begin
                res = (sa >>> sh) & mask;
                fout[2] = (res == 0);
            end
            3'd6: begin
                r = sh % w;
                res = ((a >> r) | (a << (w - r))) & mask;
                fout[2] = (res == 0);
            end
            default: begin
                for (int l = 0; l < w / 4; l++) begin
                    s = sx((a >> (4 * l)) & 15, 4) + sx((b >> (4 * l)) & 15, 4);
                    if (s > 7) s = 7;
                    if (s < -8) s = -8;
                    res = res | ((s & 15) << (4 * l));
                end
            end
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic acc;
        logic [63:0] r;
        logic [2:0] f;
        int budget;
        logic done;
        in_valid = 1'b1;
        opcode   = op;
        in1      = a;
        in2      = b;
        budget   = 0;
        done     = 1'b0;
        while (!done) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            if (acc) begin
                model(W, op, 64'(a), 64'(b), mflags, r, f);
                mflags = f;
                exp_q.push_back({f, r[W-1:0]});
                done = 1'b1;
            end else begin
                budget++;
                if (budget > 50) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: in_ready low for %0d cycles", budget);
                    done = 1'b1;
                end
            end
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int budget;
        rdy_mode = 0;
        budget = 0;
        while (exp_q.size() > 0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'h0000;
            3: return 16'hFFFF;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        logic [2:0] f;
        @(posedge clk);
        #1;
        in_valid32 = 1'b1;
        opcode32   = op;
        a32        = a;
        b32        = b;
        @(negedge clk);
        check("w32_in_ready", 64'(in_ready32), 64'd1);
        @(posedge clk);
        model(32, op, 64'(a), 64'(b), mflags32, r, f);
        mflags32 = f;
        #1;
        in_valid32 = 1'b0;
        @(negedge clk);
        check("w32_lat_s1", 64'(out_valid32), 64'd0);
        @(negedge clk);
        check("w32_lat_s2", 64'(out_valid32), 64'd1);
        check("w32_result", 64'(result32), r);
        check("w32_flags", 64'(flags32), 64'(f));
    endtask

    // ---------------- out_ready generator ----------------
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = (rdy_cnt % 3 == 0);
                    rdy_cnt++;
                end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst_n) begin
            stalled_prev = 1'b0;
        end else begin
            check("in_ready", 64'(in_ready), 64'((exp_q.size() < 2) || out_ready));
            if (stalled_prev) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_result", 64'(result), 64'(held_res));
                check("stall_flags", 64'(flags), 64'(held_flags));
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_output: result 0x%0h with nothing outstanding", result);
                end else begin
                    e = exp_q[0];
                    check("result", 64'(result), 64'(e[W-1:0]));
                    check("flags", 64'(flags), 64'(e[EW-1:W]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            stalled_prev = out_valid && !out_ready;
            held_res     = result;
            held_flags   = flags;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        opcode     = '0;
        in1        = '0;
        in2        = '0;
        in_valid32 = 1'b0;
        opcode32   = '0;
        a32        = '0;
        b32        = '0;
        out_ready32 = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // latency with no stalls
        send(3'd0, 16'd1, 16'd2);
        @(negedge clk);
        check("lat_s1", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("lat_s2", 64'(out_valid), 64'd1);
        drain();

        // reset mid-stream
        send(3'd0, 16'h7FFF, 16'h0001);
        send(3'd0, 16'h0003, 16'h0004);
        rst_n = 1'b0;
        exp_q.delete();
        mflags = 3'b000;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_flags", 64'(flags), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        idle(5);
        check("midrst_flags_after", 64'(flags), 64'd0);

        // saturating add/sub
        send(3'd0, 16'h7FFF, 16'h0001);
        send(3'd1, 16'h8000, 16'h0001);
        send(3'd0, 16'h0005, 16'hFFFB);
        drain();
        check("addsub_final_flags", 64'(flags), 64'b100);

        // shifts, then XOR leaving V/N from a prior SUB
        send(3'd4, 16'h8001, 16'd1);
        send(3'd5, 16'h8001, 16'd4);
        send(3'd6, 16'h8001, 16'd1);
        send(3'd4, 16'h8001, 16'd0);
        send(3'd1, 16'h8000, 16'h0001);
        send(3'd2, 16'h1234, 16'h1234);
        drain();
        check("xor_keeps_vn", 64'(flags), 64'b111);

        // lane saturation and byte reduction leave flags alone
        send(3'd7, 16'h7788, 16'h1111);
        send(3'd3, 16'h7F7F, 16'h7F7F);
        drain();
        check("paddsb_red_flags", 64'(flags), 64'b111);

        // back-pressure with out_ready pattern 1,0,0
        rdy_cnt  = 0;
        rdy_mode = 1;
        for (int i = 0; i < 6; i++) begin
            send(3'($urandom_range(0, 7)), rand_operand(), rand_operand());
        end
        drain();

        // randomized traffic with random back-pressure and gaps
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            send(3'($urandom_range(0, 7)), rand_operand(), rand_operand());
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        drain();

        // WIDTH=32 instance
        run32(3'd6, 32'h0000_0001, 32'd31);
        run32(3'd0, 32'h7FFF_FFFF, 32'd1);
        run32(3'd1, 32'h8000_0000, 32'd1);
        run32(3'd7, 32'h7788_8877, 32'h1111_1111);
        for (int i = 0; i < 8; i++) begin
            run32(3'($urandom_range(0, 7)), $urandom, $urandom);
        end

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
